// File: rtl/link_intf.sv
// link_intf: two-phase dual-rail link interface (transmitter + receiver).
//   clk, rst_n            : system clock, async active-low reset
//   tx_data/tx_valid      : word offered for transmission
//   tx_ready              : transmitter idle (no word awaiting acknowledge)
//   out_rail0/out_rail1   : outgoing dual-rail link (toggle = symbol)
//   out_ack               : acknowledge from the remote receiver (async)
//   in_rail0/in_rail1     : incoming dual-rail link (async)
//   in_ack                : acknowledge to the remote sender
//   rx_data/rx_valid/rx_ready : received word handshake
//   err                   : sticky protocol error
module link_intf #(
  parameter int LINK_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [LINK_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [LINK_WIDTH-1:0] out_rail0,
  output logic [LINK_WIDTH-1:0] out_rail1,
  input  logic                  out_ack,
  input  logic [LINK_WIDTH-1:0] in_rail0,
  input  logic [LINK_WIDTH-1:0] in_rail1,
  output logic                  in_ack,
  output logic [LINK_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  err
);

  logic [LINK_WIDTH-1:0] r_s0_m, r_s0, r_s1_m, r_s1;
  logic [LINK_WIDTH-1:0] r_ref0, r_ref1;
  logic                  r_ack_m, r_ack_s, r_ack_d;
  logic [LINK_WIDTH-1:0] r_rail0, r_rail1, r_rx_data;
  logic                  r_in_ack, r_rx_valid, r_err, r_phase;

  logic [LINK_WIDTH-1:0] w_ch0, w_ch1;
  logic                  w_complete, w_bad, w_ack_spur, w_tx_ready;

  // A rail has "changed" when its synchronized level differs from the level
  // captured when the previous word was acknowledged.
  assign w_ch0      = r_s0 ^ r_ref0;
  assign w_ch1      = r_s1 ^ r_ref1;
  assign w_bad      = |(w_ch0 & w_ch1);
  assign w_complete = (&(w_ch0 ^ w_ch1)) && !w_bad;

  // Transmitter is idle once the synchronized ack has caught up with phase.
  assign w_tx_ready = (r_ack_s == r_phase);
  // An ack edge arriving while the previous ack level already matched the
  // phase means no word was outstanding: a spurious acknowledge.
  assign w_ack_spur = (r_ack_s != r_ack_d) && (r_ack_d == r_phase);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s0_m     <= '0;
      r_s0       <= '0;
      r_s1_m     <= '0;
      r_s1       <= '0;
      r_ref0     <= '0;
      r_ref1     <= '0;
      r_ack_m    <= 1'b0;
      r_ack_s    <= 1'b0;
      r_ack_d    <= 1'b0;
      r_rail0    <= '0;
      r_rail1    <= '0;
      r_rx_data  <= '0;
      r_in_ack   <= 1'b0;
      r_rx_valid <= 1'b0;
      r_err      <= 1'b0;
      r_phase    <= 1'b0;
    end else begin
      r_s0_m  <= in_rail0;
      r_s0    <= r_s0_m;
      r_s1_m  <= in_rail1;
      r_s1    <= r_s1_m;
      r_ack_m <= out_ack;
      r_ack_s <= r_ack_m;
      r_ack_d <= r_ack_s;

      if (w_bad || w_ack_spur) r_err <= 1'b1;

      // Receiver: consume first, otherwise capture a complete word.
      if (r_rx_valid && rx_ready) begin
        r_in_ack   <= ~r_in_ack;
        r_ref0     <= r_s0;
        r_ref1     <= r_s1;
        r_rx_valid <= 1'b0;
      end else if (!r_rx_valid && w_complete && !r_err) begin
        r_rx_data  <= w_ch1;
        r_rx_valid <= 1'b1;
      end

      // Transmitter: one toggle per bit on the rail matching the data value.
      if (tx_valid && w_tx_ready) begin
        r_rail1 <= r_rail1 ^ tx_data;
        r_rail0 <= r_rail0 ^ ~tx_data;
        r_phase <= ~r_phase;
      end
    end
  end

  assign tx_ready  = w_tx_ready;
  assign out_rail0 = r_rail0;
  assign out_rail1 = r_rail1;
  assign in_ack    = r_in_ack;
  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign err       = r_err;

endmodule

// File: tb/tb_link_intf.sv
module tb_link_intf;
  localparam int W = 2;

  logic         clk = 0, rst_n = 0;
  logic [W-1:0] tx_data = '0, out_rail0, out_rail1, in_rail0 = '0, in_rail1 = '0, rx_data;
  logic         tx_valid = 0, tx_ready, out_ack = 0, in_ack, rx_valid, rx_ready = 0, err;

  int n_chk = 0, n_fail = 0;
  logic [W-1:0]   rx_q[$];
  logic [2*W-1:0] tx_q[$];  // {rail1, rail0}

  always #5 clk = ~clk;

  link_intf #(.LINK_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .out_rail0(out_rail0), .out_rail1(out_rail1), .out_ack(out_ack),
    .in_rail0(in_rail0), .in_rail1(in_rail1), .in_ack(in_ack),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .err(err));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // Wait (bounded) for rx_valid; compare word against scoreboard head.
  task automatic wait_rx(input string tag, input int exp_lat);
    int lat = 0;
    logic [W-1:0] e;
    while (!rx_valid && lat < 12) begin tick(); lat++; end
    chk({tag, "_valid"}, 32'(rx_valid), 1);
    if (exp_lat > 0) chk({tag, "_lat"}, lat, exp_lat);
    if (rx_q.size() == 0) chk({tag, "_sb_empty"}, 1, 0);
    else begin e = rx_q.pop_front(); chk({tag, "_data"}, 32'(rx_data), 32'(e)); end
  endtask

  task automatic send_tx(input logic [W-1:0] d);
    logic [2*W-1:0] e;
    tx_q.push_back({out_rail1 ^ d, out_rail0 ^ ~d});
    tx_data = d; tx_valid = 1;
    tick();
    tx_valid = 0;
    e = tx_q.pop_front();
    chk("tx_rails", 32'({out_rail1, out_rail0}), 32'(e));
    chk("tx_busy", 32'(tx_ready), 0);
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_rails", 32'({out_rail1, out_rail0}), 0);
    chk("rst_in_ack", 32'(in_ack), 0);
    chk("rst_rx_valid", 32'(rx_valid), 0);
    chk("rst_err", 32'(err), 0);
    tick(2); rst_n = 1; tick();
    chk("rst_tx_ready", 32'(tx_ready), 1);

    // word 1: 2'b10 with rx_ready=1
    rx_ready = 1;
    in_rail0[0] = ~in_rail0[0]; tick(4);
    chk("w1_partial", 32'(rx_valid), 0);
    in_rail1[1] = ~in_rail1[1]; rx_q.push_back(2'b10);
    wait_rx("w1", 3);
    tick();
    chk("w1_one_cycle", 32'(rx_valid), 0);
    chk("w1_in_ack", 32'(in_ack), 1);

    // word 2: 2'b01
    in_rail1[0] = ~in_rail1[0]; tick(2);
    in_rail0[1] = ~in_rail0[1]; rx_q.push_back(2'b01);
    wait_rx("w2", 3);
    tick();
    chk("w2_in_ack", 32'(in_ack), 0);

    // backpressure: 2'b11, held until rx_ready
    rx_ready = 0;
    in_rail1 = ~in_rail1; rx_q.push_back(2'b11);
    wait_rx("bp", 3);
    tick(4);
    chk("bp_hold", 32'(rx_valid), 1);
    chk("bp_data", 32'(rx_data), 32'(2'b11));
    chk("bp_in_ack", 32'(in_ack), 0);
    rx_ready = 1; tick();
    chk("bp_rel_ack", 32'(in_ack), 1);
    chk("bp_rel_valid", 32'(rx_valid), 0);

    // long partial then complete: 2'b00
    in_rail0[0] = ~in_rail0[0]; tick(6);
    chk("part_valid", 32'(rx_valid), 0);
    chk("part_in_ack", 32'(in_ack), 1);
    in_rail0[1] = ~in_rail0[1]; rx_q.push_back(2'b00);
    wait_rx("w4", 3);
    tick();
    chk("w4_in_ack", 32'(in_ack), 0);

    // transmit
    send_tx(2'b10);
    chk("tx1_r0", 32'(out_rail0), 32'(2'b01));
    chk("tx1_r1", 32'(out_rail1), 32'(2'b10));
    out_ack = ~out_ack; tick();
    chk("tx1_ack_e1", 32'(tx_ready), 0);
    tick();
    chk("tx1_ack_e2", 32'(tx_ready), 1);
    send_tx(2'b01);
    chk("tx2_r0", 32'(out_rail0), 32'(2'b11));
    chk("tx2_r1", 32'(out_rail1), 32'(2'b11));
    out_ack = ~out_ack; tick(2);
    chk("tx2_ready", 32'(tx_ready), 1);
    chk("tx_no_err", 32'(err), 0);

    // rail conflict on bit 1
    in_rail0[1] = ~in_rail0[1]; in_rail1[1] = ~in_rail1[1];
    tick(4);
    chk("err_set", 32'(err), 1);
    chk("err_no_valid", 32'(rx_valid), 0);
    in_rail0[0] = ~in_rail0[0]; tick(6);
    chk("err_sticky", 32'(err), 1);
    chk("err_no_word", 32'(rx_valid), 0);

    // reset to clear, then build up rx_valid=1 and outstanding tx
    rst_n = 0; in_rail0 = '0; in_rail1 = '0; out_ack = 0;
    #1 chk("err_clear", 32'(err), 0);
    tick(2); rst_n = 1; tick();
    rx_ready = 0;
    in_rail1[0] = ~in_rail1[0]; in_rail0[1] = ~in_rail0[1]; rx_q.push_back(2'b01);
    wait_rx("pre_rst", 3);
    send_tx(2'b11);
    rst_n = 0; in_rail0 = '0; in_rail1 = '0;
    #1;
    chk("mid_rst_outs", 32'({out_rail1, out_rail0, in_ack, rx_valid, rx_data, err}), 0);
    tick(2); rst_n = 1; tick();
    chk("post_rst_ready", 32'(tx_ready), 1);

    // spurious ack while idle
    out_ack = 1; tick(5);
    chk("spur_ack_err", 32'(err), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule

// File: doc/link_intf.md
LINK_INTF -- requirements
Module: link_intf

Interface
REQ-001 SHALL have parameter LINK_WIDTH, default 2: number of data bits per link word.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port tx_data  input  LINK_WIDTH  word to transmit.
REQ-005 SHALL have port tx_valid  input  1  tx_data offered.
REQ-006 SHALL have port tx_ready  output  1  transmitter idle, may accept a word.
REQ-007 SHALL have port out_rail0 / out_rail1  output  LINK_WIDTH each  outgoing two-phase dual-rail link, rail0 = "0" rail, rail1 = "1" rail.
REQ-008 SHALL have port out_ack  input  1  asynchronous two-phase acknowledge from the link receiver.
REQ-009 SHALL have port in_rail0 / in_rail1  input  LINK_WIDTH each  incoming asynchronous two-phase dual-rail link.
REQ-010 SHALL have port in_ack  output  1  two-phase acknowledge to the link sender.
REQ-011 SHALL have port rx_data  output  LINK_WIDTH  received word.
REQ-012 SHALL have port rx_valid  output  1  rx_data holds an unconsumed word.
REQ-013 SHALL have port rx_ready  input  1  consumer accepts rx_data.
REQ-014 SHALL have port err  output  1  sticky protocol error flag.

Function
REQ-015 Encoding SHALL be two-phase dual-rail: per bit, one toggle of rail1 encodes 1, one toggle of rail0 encodes 0; a word is one toggle on exactly one rail of every bit; acknowledge is one toggle of ack.
REQ-016 in_rail0, in_rail1 and out_ack SHALL each pass through a two-flop synchronizer before any use.
REQ-017 Receiver SHALL keep reference copies ref0/ref1 of the synchronized input rails; per bit, ch0 = sync0^ref0 and ch1 = sync1^ref1.
REQ-018 Word complete SHALL mean ch0^ch1 = 1 for every bit and no bit has ch0&ch1.
REQ-019 On the first edge where a word is complete and rx_valid = 0, rx_data SHALL load ch1 and rx_valid SHALL go 1; rx_valid thus rises on the 3rd rising edge after the last rail toggle.
REQ-020 A partial word SHALL leave rx_valid, rx_data and in_ack unchanged.
REQ-021 On an edge with rx_valid&rx_ready, in_ack SHALL toggle, ref0/ref1 SHALL load the current synchronized rails, and rx_valid SHALL clear.
REQ-022 rx_data SHALL hold stable while rx_valid = 1.
REQ-023 If any bit has ch0&ch1, err SHALL set and stay 1 until reset; no further words SHALL be delivered.
REQ-024 tx_ready SHALL equal 1 when no transmission is outstanding, i.e. the synchronized out_ack equals the transmitter phase bit.
REQ-025 On an edge with tx_valid&tx_ready, for each bit i, out_rail1[i] SHALL toggle if tx_data[i] = 1, else out_rail0[i] SHALL toggle; the phase bit SHALL toggle, so tx_ready is 0 from the next cycle.
REQ-026 tx_ready SHALL return to 1 on the 2nd rising edge after out_ack toggles; extra out_ack toggles while idle SHALL set err.
REQ-027 Transmitter and receiver SHALL operate independently; simultaneous events on both SHALL both take effect in the same cycle.
REQ-028 Output rails and in_ack SHALL be driven directly from flops (glitch-free).

Reset
REQ-029 While rst_n = 0, all synchronizers, ref0/ref1, out_rail0, out_rail1, in_ack, rx_data, rx_valid, err and the phase bit SHALL be 0, so tx_ready = 1 once out_ack is 0.
REQ-030 Reset asserted mid-word SHALL discard any partial receive or outstanding transmit; the link peers are also reset.

Verification
REQ-031 Rx word: after reset, toggle in_rail0[0], then in_rail1[1], rx_ready = 1 -> rx_data = 2'b10, rx_valid one cycle, in_ack 0->1.
REQ-032 Second word: toggle in_rail1[0], then in_rail0[1] -> rx_data = 2'b01, in_ack 1->0.
REQ-033 Partial/backpressure: only in_rail0[0] toggled -> rx_valid stays 0; complete word with rx_ready = 0 -> rx_valid holds, in_ack unchanged until rx_ready = 1.
REQ-034 Error: toggle in_rail0[1] and in_rail1[1] in one word -> err = 1, rx_valid stays 0, err persists until rst_n low.
REQ-035 Tx: tx_data = 2'b10, tx_valid = 1 -> out_rail0 = 2'b01, out_rail1 = 2'b10, tx_ready = 0; toggle out_ack -> tx_ready = 1 two edges later; tx_data = 2'b01 -> out_rail0 = 2'b11, out_rail1 = 2'b11.
REQ-036 Reset mid-op: rst_n low with rx_valid = 1 and tx outstanding -> all outputs 0 immediately, tx_ready = 1 after release.
